// File: rtl/image_stream_proc.sv
// Streams a frame out of an external frame buffer through a per-pixel point
// operation (add/subtract/threshold/invert) onto a valid-ready output port.
module image_stream_proc #(
    parameter int unsigned WIDTH          = 768,
    parameter int unsigned HEIGHT         = 512,
    parameter int unsigned PPC            = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned START_UP_DELAY = 100,
    parameter int unsigned H_SYNC_DELAY   = 160,
    parameter int unsigned FLIP_V         = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [2:0]                            mode,
    input  logic [DATA_WIDTH-1:0]                 value,
    input  logic [DATA_WIDTH-1:0]                 threshold,
    output logic                                  rd_en,
    output logic [$clog2(WIDTH*HEIGHT/PPC)-1:0]   rd_addr,
    input  logic [3*PPC*DATA_WIDTH-1:0]           rd_data,
    output logic                                  vsync,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [3*PPC*DATA_WIDTH-1:0]           out_pix,
    output logic                                  out_sof,
    output logic                                  out_eol,
    output logic                                  out_eof,
    output logic                                  busy,
    output logic                                  frame_done
);

    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned PW   = 3 * PPC * DW;
    localparam int unsigned BPL  = WIDTH / PPC;
    localparam int unsigned AW   = $clog2(WIDTH * HEIGHT / PPC);
    localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned MAXD = (START_UP_DELAY > H_SYNC_DELAY) ? START_UP_DELAY : H_SYNC_DELAY;
    localparam int unsigned CNTW = (MAXD > 1) ? $clog2(MAXD + 1) : 1;

    localparam logic [AW-1:0]   LAST_COL   = AW'(BPL - 1);
    localparam logic [AW-1:0]   BPL_A      = AW'(BPL);
    localparam logic [AW-1:0]   FIRST_BASE = (FLIP_V != 0) ? AW'((HEIGHT - 1) * BPL) : '0;
    localparam logic [RW-1:0]   LAST_ROW   = RW'(HEIGHT - 1);
    localparam logic [CNTW-1:0] SU_LAST    = CNTW'(START_UP_DELAY - 1);
    localparam logic [CNTW-1:0] HS_LAST    = CNTW'(H_SYNC_DELAY - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic            start_q;
    logic [2:0]      mode_q, mode_d;
    logic [DW-1:0]   value_q, value_d;
    logic [DW-1:0]   thr_q, thr_d;
    logic [CNTW-1:0] dly_q, dly_d;
    logic [AW-1:0]   col_q, col_d;
    logic [AW-1:0]   base_q, base_d;
    logic [RW-1:0]   row_q, row_d;
    logic            outst_q;
    logic [2:0]      pflg_q, pflg_d;
    logic [PW-1:0]   buf_pix_q [2];
    logic [2:0]      buf_flg_q [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      cnt_q, cnt_d;

    logic            start_rise;
    logic            pop;
    logic            push;
    logic [1:0]      occ;
    logic            can_issue;
    logic [PW-1:0]   proc_beat;

    function automatic logic [PW-1:0] process_beat(
        input logic [PW-1:0] beat,
        input logic [2:0]    m,
        input logic [DW-1:0] v,
        input logic [DW-1:0] t
    );
        logic [PW-1:0] res;
        logic [DW-1:0] ch;
        logic [DW-1:0] r;
        logic [DW:0]   wide;
        logic [DW+1:0] sum;
        logic [DW+1:0] lim;
        res  = '0;
        r    = '0;
        wide = '0;
        lim  = {2'b00, t} + {2'b00, t} + {2'b00, t};
        for (int unsigned k = 0; k < PPC; k++) begin
            sum = {2'b00, beat[k*3*DW +: DW]} + {2'b00, beat[k*3*DW+DW +: DW]}
                + {2'b00, beat[k*3*DW+2*DW +: DW]};
            for (int unsigned c = 0; c < 3; c++) begin
                ch = beat[(k*3+c)*DW +: DW];
                case (m)
                    3'b001: begin
                        wide = {1'b0, ch} + {1'b0, v};
                        r    = wide[DW] ? '1 : wide[DW-1:0];
                    end
                    3'b010: begin
                        wide = {1'b0, ch} - {1'b0, v};
                        r    = wide[DW] ? '0 : wide[DW-1:0];
                    end
                    3'b011:  r = (sum > lim) ? '1 : '0;
                    3'b100:  r = ~ch;
                    default: r = ch;
                endcase
                res[(k*3+c)*DW +: DW] = r;
            end
        end
        return res;
    endfunction

    assign start_rise = start & ~start_q;
    assign pop        = (cnt_q != 2'd0) & out_ready;
    assign push       = outst_q;
    // Occupancy the buffer will reach if nothing more is issued; a new read
    // is allowed only while that leaves room for its returning beat.
    assign occ        = cnt_q + {1'b0, outst_q} - {1'b0, pop};
    assign can_issue  = (occ < 2'd2);

    always_comb begin
        proc_beat = process_beat(rd_data, mode_q, value_q, thr_q);
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        value_d    = value_q;
        thr_d      = thr_q;
        dly_d      = dly_q;
        col_d      = col_q;
        row_d      = row_q;
        base_d     = base_q;
        pflg_d     = pflg_q;
        rd_en      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_VSYNC;
                    mode_d  = mode;
                    value_d = value;
                    thr_d   = threshold;
                    dly_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = FIRST_BASE;
                end
            end
            S_VSYNC: begin
                if (dly_q == SU_LAST) begin
                    state_d = S_HSYNC;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_HSYNC: begin
                if (dly_q == HS_LAST) begin
                    state_d = S_DATA;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_DATA: begin
                if (can_issue) begin
                    rd_en  = 1'b1;
                    pflg_d = {(row_q == '0) && (col_q == '0),
                              col_q == LAST_COL,
                              (col_q == LAST_COL) && (row_q == LAST_ROW)};
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_HSYNC;
                            row_d   = row_q + 1'b1;
                            base_d  = (FLIP_V != 0) ? base_q - BPL_A : base_q + BPL_A;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if ((cnt_q == 2'd0) && !outst_q) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            // Track the live level so a start held through reset is not an edge.
            start_q  <= start;
            mode_q   <= '0;
            value_q  <= '0;
            thr_q    <= '0;
            dly_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            base_q   <= '0;
            pflg_q   <= '0;
            outst_q  <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            mode_q   <= mode_d;
            value_q  <= value_d;
            thr_q    <= thr_d;
            dly_q    <= dly_d;
            col_q    <= col_d;
            row_q    <= row_d;
            base_q   <= base_d;
            pflg_q   <= pflg_d;
            outst_q  <= rd_en;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pix_q[wr_ptr_q] <= proc_beat;
            buf_flg_q[wr_ptr_q] <= pflg_q;
        end
    end

    assign rd_addr   = base_q + col_q;
    assign vsync     = (state_q == S_VSYNC);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (cnt_q != 2'd0);
    assign out_pix   = out_valid ? buf_pix_q[rd_ptr_q] : '0;
    assign out_sof   = out_valid & buf_flg_q[rd_ptr_q][2];
    assign out_eol   = out_valid & buf_flg_q[rd_ptr_q][1];
    assign out_eof   = out_valid & buf_flg_q[rd_ptr_q][0];

endmodule

// File: doc/image_stream_proc.md
IMAGE_STREAM_PROC -- requirements
Module: image_stream_proc

Interface
REQ-001 SHALL have parameter WIDTH, default 768, image width in pixels; WIDTH % PPC == 0.
REQ-002 SHALL have parameter HEIGHT, default 512, image height in lines.
REQ-003 SHALL have parameter PPC, default 2, pixels per output beat (1, 2 or 4).
REQ-004 SHALL have parameter DATA_WIDTH, default 8, bits per colour channel.
REQ-005 SHALL have parameter START_UP_DELAY, default 100, vsync cycles before the first line.
REQ-006 SHALL have parameter H_SYNC_DELAY, default 160, blanking cycles before every line.
REQ-007 SHALL have parameter FLIP_V, default 1; 1 = frame buffer stored bottom-up (BMP order).
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-010 SHALL have port start, input, 1, frame request, sampled on a rising edge.
REQ-011 SHALL have port mode, input, 3, 000 pass, 001 add, 010 subtract, 011 threshold, 100 invert, others pass.
REQ-012 SHALL have port value, input, DATA_WIDTH, brightness offset.
REQ-013 SHALL have port threshold, input, DATA_WIDTH, threshold level.
REQ-014 SHALL have port rd_en, output, 1, frame-buffer read strobe.
REQ-015 SHALL have port rd_addr, output, clog2(WIDTH*HEIGHT/PPC), beat address.
REQ-016 SHALL have port rd_data, input, 3*PPC*DATA_WIDTH, beat returned exactly 1 cycle after rd_en; pixel k at bits [k*3*DW +: 3*DW], ordered {B,G,R}.
REQ-017 SHALL have port vsync, output, 1, high throughout VSYNC state.
REQ-018 SHALL have port out_valid/out_ready, output/input, 1 each, valid-ready handshake.
REQ-019 SHALL have port out_pix, output, 3*PPC*DATA_WIDTH, processed beat, same packing as rd_data.
REQ-020 SHALL have port out_sof/out_eol/out_eof, output, 1 each, first beat of frame / last beat of line / last beat of frame.
REQ-021 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-022 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.

Function
REQ-023 States SHALL be IDLE, VSYNC, HSYNC, DATA, DRAIN; IDLE->VSYNC on start rising edge; VSYNC->HSYNC after START_UP_DELAY cycles; HSYNC->DATA after H_SYNC_DELAY cycles; DATA->HSYNC after last read of a line unless last line; DATA->DRAIN after last read of frame; DRAIN->IDLE when output buffer empty and no read outstanding.
REQ-024 mode, value, threshold SHALL be latched on IDLE->VSYNC; changes mid-frame SHALL be ignored; start while busy SHALL be ignored.
REQ-025 Reads SHALL be issued only in DATA, in raster order, WIDTH/PPC per line; line r SHALL read address (FLIP_V ? HEIGHT-1-r : r)*WIDTH/PPC + c.
REQ-026 A 2-entry output buffer SHALL hold processed beats; rd_en SHALL assert only when (entries + outstanding - pop) < 2, guaranteeing no overflow; DATA SHALL stall (not advance) while issue is blocked.
REQ-027 With out_ready held high, throughput SHALL be one beat per cycle within a line; first beat valid 2 cycles after the first rd_en.
REQ-028 While out_valid=1 and out_ready=0, out_pix and sideband flags SHALL hold stable; no beat dropped or duplicated.
REQ-029 add: per channel min(c+value, 2^DW-1); subtract: max(c-value, 0); invert: (2^DW-1)-c; arithmetic DW+1 bits wide.
REQ-030 threshold: per pixel, if R+G+B > 3*threshold (DW+2 bits) all channels = 2^DW-1, else 0.
REQ-031 frame_done SHALL pulse in the cycle the DRAIN->IDLE transition occurs.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE and clear counters, buffer and outstanding flag; rd_en, vsync, out_valid, out_sof, out_eol, out_eof, busy, frame_done, out_pix SHALL read 0 the following cycle, including mid-frame; start edge detector SHALL be cleared so start held high through reset does not launch a frame.

Verification (WIDTH=8, HEIGHT=4, PPC=2, DW=8, START_UP_DELAY=3, H_SYNC_DELAY=2, FLIP_V=1)
REQ-033 mode=001, value=100: channel 200 -> 255, channel 100 -> 200; 16 beats, out_sof on beat 0, out_eol on beats 3,7,11,15, out_eof on beat 15, one frame_done.
REQ-034 mode=010, value=100: channel 50 -> 0, 180 -> 80.
REQ-035 mode=011, threshold=90: pixel (100,100,100) -> (255,255,255); (90,90,90) -> (0,0,0).
REQ-036 rd_addr sequence 12,13,14,15,8,...,3; vsync high exactly 3 cycles; out_ready low 5 cycles mid-line -> out_pix frozen, 16 unique beats total, rd_en never asserted with 2 entries held.
REQ-037 rst_n low for 1 cycle at beat 6 -> all outputs 0 next cycle, busy=0; subsequent start yields a complete 16-beat frame.
REQ-038 mode changed 001->100 and start pulsed mid-frame -> frame completes entirely in add mode, no second frame.
